// File: rtl/rca64_op_seq_if.sv
// Request and result handshake bundle for the ripple-carry adder operand sequencer.
// master = requester/consumer side, slave = sequencer side.
interface rca64_op_seq_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/rca64_op_seq.sv
// Operand sequencer and result capture around an external combinational ripple-carry adder.
// Registers operands, waits SETTLE_CYC edges for the carry ripple, then holds the result until taken.
module rca64_op_seq #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    rca64_op_seq_if.slave    bus,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             busy
);
    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("rca64_op_seq: SETTLE_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_cout_q;
    logic             out_ovf_q;
    logic             in_ready_c;
    logic             accept_c;

    // Ready combinationally follows out_ready in HOLD so retire and accept share one edge.
    assign in_ready_c = (state == IDLE) | ((state == HOLD) & bus.out_ready);
    assign accept_c   = bus.in_valid & in_ready_c;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_ovf   = out_ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            add_a       <= '0;
            add_b       <= '0;
            add_cin     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Operand load is shared by IDLE accepts and back-to-back accepts from HOLD.
            if (accept_c) begin
                add_a   <= bus.in_a;
                add_b   <= bus.in_sub ? ~bus.in_b : bus.in_b;
                add_cin <= bus.in_sub;
                cnt     <= CNT_W'(SETTLE_CYC - 1);
                state   <= SETTLE;
                busy    <= 1'b1;
            end
            case (state)
                IDLE: ;
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        out_sum_q   <= add_sum;
                        out_cout_q  <= add_cout;
                        out_ovf_q   <= (add_a[WIDTH-1] == add_b[WIDTH-1]) &
                                       (add_sum[WIDTH-1] != add_a[WIDTH-1]);
                        out_valid_q <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (!bus.in_valid) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rca64_op_seq.sv
// Directed bench for rca64_op_seq with a behavioural a+b+cin adder attached.
module tb_rca64_op_seq;
    localparam int unsigned W = 64;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_cin;
    logic [W-1:0]  add_sum;
    logic          add_cout;
    logic          busy;
    int            errors;
    int            checks;

    rca64_op_seq_if #(.WIDTH(W)) bus ();

    rca64_op_seq #(.WIDTH(W), .SETTLE_CYC(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .busy     (busy)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE, verify 2-edge latency and result, then retire it.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic [W-1:0] esum, input logic ecout,
                         input logic eovf);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        chk({tag, "_in_ready_idle"}, W'(bus.in_ready), W'(1));
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_add_b"}, add_b, sub ? ~b : b);
        chk({tag, "_busy"}, W'(busy), W'(1));
        tick();
        chk({tag, "_valid_early"}, W'(bus.out_valid), W'(0));
        tick();
        chk({tag, "_valid"}, W'(bus.out_valid), W'(1));
        chk({tag, "_sum"}, bus.out_sum, esum);
        chk({tag, "_cout"}, W'(bus.out_cout), W'(ecout));
        chk({tag, "_ovf"}, W'(bus.out_ovf), W'(eovf));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_retired"}, W'(bus.out_valid), W'(0));
        chk({tag, "_idle"}, W'(busy), W'(0));
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", W'(bus.out_valid), W'(0));
        chk("rst_out_sum", bus.out_sum, W'(0));
        chk("rst_add_a", add_a, W'(0));
        chk("rst_add_b", add_b, W'(0));
        chk("rst_add_cin", W'(add_cin), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_in_ready", W'(bus.in_ready), W'(1));
        tick();
        #2 rst_n = 1'b1;
        tick();

        do_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
        do_op("sub_5m7", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        do_op("sub_7m5", 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0);
        do_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        do_op("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Backpressure: hold 10+20 while a new request waits, then retire and accept together.
        bus.in_valid = 1'b1;
        bus.in_a     = 64'd10;
        bus.in_b     = 64'd20;
        bus.in_sub   = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("bp_valid", W'(bus.out_valid), W'(1));
        bus.in_valid = 1'b1;
        bus.in_a     = 64'd3;
        bus.in_b     = 64'd4;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", W'(bus.in_ready), W'(0));
            tick();
            chk("bp_hold_valid", W'(bus.out_valid), W'(1));
            chk("bp_hold_sum", bus.out_sum, 64'd30);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_ready_passthru", W'(bus.in_ready), W'(1));
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("bp_drop_valid", W'(bus.out_valid), W'(0));
        chk("bp_busy", W'(busy), W'(1));
        chk("bp_add_a", add_a, 64'd3);
        tick();
        chk("bp_valid_early", W'(bus.out_valid), W'(0));
        tick();
        chk("bp_next_valid", W'(bus.out_valid), W'(1));
        chk("bp_next_sum", bus.out_sum, 64'd7);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_retired", W'(busy), W'(0));

        // Reset in SETTLE must discard the operation.
        bus.in_valid = 1'b1;
        bus.in_a     = 64'd100;
        bus.in_b     = 64'd1;
        bus.in_sub   = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        chk("mid_busy", W'(busy), W'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", W'(busy), W'(0));
        chk("mid_rst_add_a", add_a, W'(0));
        chk("mid_rst_valid", W'(bus.out_valid), W'(0));
        chk("mid_rst_sum", bus.out_sum, W'(0));
        chk("mid_rst_in_ready", W'(bus.in_ready), W'(1));
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_no_stale", W'(bus.out_valid), W'(0));
        end
        do_op("post_rst_op", 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
